// File: rtl/mp_rfx.sv
`default_nettype none
// ============================================================================
//  Module      : mp_rfx
//  Description : Multi-port half-addressable register file with same-cycle
//                write->read bypass and a per-half pending scoreboard that
//                drives operand-ready stalls for long-latency producers.
//  Revision    : 1.0  initial release
// ============================================================================
module mp_rfx #(
  parameter int XLEN   = 32,
  parameter int NREG   = 16,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int HW    = XLEN / 2,
  localparam int AW    = $clog2(NREG) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  input  logic [NRD-1:0]       rd_full,
  output logic [NRD*HW-1:0]    rd_data,
  output logic [NRD*XLEN-1:0]  rd_data_f,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR-1:0]       wr_full,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 sb_set,
  input  logic                 sb_full,
  input  logic [AW-1:0]        sb_addr,
  output logic                 busy_any,
  output logic                 wr_conflict
);

  // Half-slot index is the half address itself: {register, half}.
  localparam int NH = 2 * NREG;
  localparam int RW = AW - 1;

  // Stored state
  logic [HW-1:0] mem [NH];
  logic [NH-1:0] sb;

  // Per-write-port decode: which halves the port really writes, and the data
  // it presents to each half.  Writes to register 0 are dropped here so they
  // neither commit, clear the scoreboard nor count towards a conflict.
  logic [RW-1:0] wr_reg [NWR];
  logic [NWR-1:0] wr_lo;
  logic [NWR-1:0] wr_hi;
  logic [HW-1:0] wr_dlo [NWR];
  logic [HW-1:0] wr_dhi [NWR];

  for (genvar i = 0; i < NWR; i++) begin : g_wr
    assign wr_reg[i] = wr_addr[i*AW+1 +: RW];
    assign wr_lo[i]  = wr_en[i] && (wr_reg[i] != '0) && (wr_full[i] || !wr_addr[i*AW]);
    assign wr_hi[i]  = wr_en[i] && (wr_reg[i] != '0) && (wr_full[i] ||  wr_addr[i*AW]);
    // A half write always carries its payload in the low half of wr_data.
    assign wr_dlo[i] = wr_data[i*XLEN +: HW];
    assign wr_dhi[i] = wr_full[i] ? wr_data[i*XLEN+HW +: HW] : wr_data[i*XLEN +: HW];
  end

  // Scoreboard set decode (register 0 never becomes pending)
  logic [RW-1:0] sb_reg;
  logic          sb_lo;
  logic          sb_hi;

  assign sb_reg = sb_addr[AW-1:1];
  assign sb_lo  = sb_set && (sb_reg != '0) && (sb_full || !sb_addr[0]);
  assign sb_hi  = sb_set && (sb_reg != '0) && (sb_full ||  sb_addr[0]);

  // Per-half-slot write winner; ports are scanned in ascending order so the
  // highest-index writer overrides, and a second hit flags a conflict.
  logic [NH-1:0] win_v;
  logic [HW-1:0] win_d [NH];
  logic [NH-1:0] multi;
  logic [NH-1:0] sb_hit;

  // Resolve the winning writer, conflicts and scoreboard sets per half-slot
  always_comb begin
    win_v  = '0;
    multi  = '0;
    sb_hit = '0;
    for (int s = 0; s < NH; s++) begin
      win_d[s] = '0;
      for (int i = 0; i < NWR; i++) begin
        if ((wr_reg[i] == RW'(s >> 1)) && (((s % 2) == 1) ? wr_hi[i] : wr_lo[i])) begin
          if (win_v[s]) begin
            multi[s] = 1'b1;
          end
          win_v[s] = 1'b1;
          win_d[s] = ((s % 2) == 1) ? wr_dhi[i] : wr_dlo[i];
        end
      end
      if ((sb_reg == RW'(s >> 1)) && (((s % 2) == 1) ? sb_hi : sb_lo)) begin
        sb_hit[s] = 1'b1;
      end
    end
  end

  // Commit writes, update the scoreboard (set beats clear) and register the conflict pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NH; s++) begin
        mem[s] <= '0;
      end
      sb          <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int s = 0; s < NH; s++) begin
        if (win_v[s]) begin
          mem[s] <= win_d[s];
        end
      end
      sb          <= sb_hit | (sb & ~win_v);
      wr_conflict <= |multi;
    end
  end

  assign busy_any = |sb;

  // Read ports: each half is forwarded from a same-cycle winner when bypass
  // is enabled, and a half being written is then no longer reported busy.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [RW-1:0] rreg;
    logic [AW-1:0] slo;
    logic [AW-1:0] shi;
    logic [HW-1:0] dlo;
    logic [HW-1:0] dhi;
    logic          blo;
    logic          bhi;

    assign rreg = rd_addr[p*AW+1 +: RW];
    assign slo  = {rreg, 1'b0};
    assign shi  = {rreg, 1'b1};

    // Select stored or forwarded half data and busy for this port
    always_comb begin
      dlo = mem[slo];
      dhi = mem[shi];
      blo = sb[slo];
      bhi = sb[shi];
      if (BYPASS != 0) begin
        if (win_v[slo]) begin
          dlo = win_d[slo];
          blo = 1'b0;
        end
        if (win_v[shi]) begin
          dhi = win_d[shi];
          bhi = 1'b0;
        end
      end
      if (rreg == '0) begin
        dlo = '0;
        dhi = '0;
        blo = 1'b0;
        bhi = 1'b0;
      end
    end

    assign rd_data_f[p*XLEN +: XLEN] = {dhi, dlo};
    assign rd_data[p*HW +: HW]       = rd_addr[p*AW] ? dhi : dlo;
    assign rd_busy[p]                = rd_full[p] ? (blo | bhi) : (rd_addr[p*AW] ? bhi : blo);
  end

endmodule
`default_nettype wire
